dclk_sel_ctrl: RTL and testbench
================================

# dclk_sel_ctrl

Glitch-free switching controller for the divided-clock bank (÷2, ÷4, ÷8, ÷3 outputs of the clock divider). It owns the 2-bit select, gates the divided output off before a switch, and reopens it only on a low phase of the new source. Selection changes come from an external request/ready handshake or from an optional auto-rotate scheduler with programmable dwell. It sits between the divider bank and every consumer of the selected divided clock.

## Interface

- `DWELL_W`, default 8: width of the dwell count.
- `clk` input 1: system clock; the divider bank also runs on it.
- `rst_n` input 1: asynchronous, active-low reset.
- `div_in` input 4: divider levels. [0]=clk1_2, [1]=clk1_4, [2]=clk1_8, [3]=clk1_3. All are registered on `clk`.
- `req_valid` input 1: external switch request.
- `req_sel` input 2: requested source index.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `auto_en` input 1: enables auto-rotate.
- `dwell` input DWELL_W: auto-rotate period in RUN cycles. 0 disables rotation.
- `sel` output 2: current source index.
- `gate_en` output 1: output gate.
- `dclk_out` output 1: registered gated clock, `gate_en & div_in[sel]`.
- `busy` output 1: high in any state except RUN.
- `switch_done` output 1: one-cycle pulse when the gate opens after a switch or after a same-source request.

## Operation

- FSM states: RUN, DRAIN, GAP, ALIGN. Registered `tgt[1:0]` holds the pending target.
- **RUN**
  - `gate_en`=1 and `req_ready`=1.
  - On accept with `req_sel==sel`: stay in RUN and pulse `switch_done` next cycle.
  - On accept with `req_sel!=sel`: `tgt<=req_sel`, go to DRAIN.
- **DRAIN**
  - Wait for `div_in[sel]==0`.
  - On that edge: `gate_en<=0`, go to GAP.
- **GAP**: one cycle. `sel<=tgt`, go to ALIGN.
- **ALIGN**
  - Wait for `div_in[sel]==0`.
  - On that edge: `gate_en<=1`, `switch_done<=1`, clear dwell counter, go to RUN.
- `req_ready`=0 outside RUN. Requests presented then are neither accepted nor queued; the requester holds `req_valid`.
- **Auto-rotate**
  - `dwell_cnt` increments each RUN cycle when `auto_en=1`, `dwell!=0` and no request is accepted.
  - When `dwell_cnt >= dwell-1` (`>=` covers `dwell` lowered mid-count), generate an internal request for `tgt=(sel+1) mod 4` and enter DRAIN. Index 3 wraps to 0.
  - `auto_en=0` or `dwell==0` holds `dwell_cnt` at 0.
  - External accept in the same cycle wins; `dwell_cnt` clears.
- `dclk_out` is registered: `dclk_out <= gate_en & div_in[sel]`, using pre-edge register values.
- While `gate_en`=0, `dclk_out` is 0 from the next cycle onward.

## Timing

- Reset (asynchronous, immediate) values:
  - state=ALIGN, `sel`=0, `tgt`=0, `gate_en`=0, `dclk_out`=0
  - `req_ready`=0, `busy`=1, `switch_done`=0, `dwell_cnt`=0
- After reset the gate opens on the first edge with `div_in[0]==0`. No `switch_done` pulse is produced for the post-reset opening; the pulse is suppressed with a reset flag.
- Minimum switch latency, with accept on edge t and both sources already low:
  - edge t+1: `gate_en`=0
  - edge t+2: `sel`=new
  - edge t+3: `gate_en`=1 and `switch_done`=1
  - edge t+4: `switch_done`=0
- Worst case adds the remaining high phase of the old source plus the remaining high phase of the new source.
- Same-source request: `switch_done` high for edge t+1 only. `gate_en` never drops.
- Reset asserted mid-switch: the pending target is discarded, no `switch_done`, and the block re-aligns on source 0.
- `busy` and `req_ready` are combinational from state. `busy == !req_ready`.

## Test plan

- **Reset release**, divider bank running from the same reset: `sel`=0 and `gate_en` rises on the first `div_in[0]==0` edge. `switch_done` stays 0. `dclk_out` then toggles with a period of 2 cycles.
- **External switch 0→2**: request `req_sel=2` while `div_in[0]=1`.
  - `gate_en` falls after `div_in[0]` goes low.
  - `sel=2` exactly one cycle later.
  - `gate_en` and `switch_done` rise on the first `div_in[2]==0` edge.
  - `dclk_out` shows no pulse narrower than 1 cycle.
- **Same-source request**: `req_sel=sel` -> one-cycle `switch_done`. `gate_en` stays 1 and `busy` stays 0.
- **Auto-rotate**, `auto_en=1`, `dwell=5`:
  - `sel` sequence 0→1→2→3→0.
  - DRAIN is entered after exactly 5 RUN cycles each time.
  - Assert wrap-around from 3 to 0.
- **Priority**: `req_valid` with `req_sel=3` on the same edge the dwell expires -> `tgt=3`, not `sel+1`, and `dwell_cnt` clears.
- **Mid-switch reset**: pull `rst_n` low during GAP.
  - All outputs take reset values immediately.
  - After release, `sel=0` and no `switch_done`.
  - A `req_valid` held throughout is accepted only once RUN is reached.

Source files
------------

// File: rtl/dclk_sel_ctrl.sv
// Glitch-free select controller for the divided-clock bank: closes the output gate on a
// low phase of the old source, moves the select, then reopens on a low phase of the new one.
module dclk_sel_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         div_in,
  input  logic               req_valid,
  input  logic [1:0]         req_sel,
  output logic               req_ready,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               gate_en,
  output logic               dclk_out,
  output logic               busy,
  output logic               switch_done
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_GAP,
    ST_ALIGN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           tgt_q, tgt_d;
  logic                 gate_q, gate_d;
  logic                 dclk_q, dclk_d;
  logic                 done_q, done_d;
  logic                 boot_q, boot_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 rot_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALIGN;
      sel_q   <= '0;
      tgt_q   <= '0;
      gate_q  <= 1'b0;
      dclk_q  <= 1'b0;
      done_q  <= 1'b0;
      boot_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      gate_q  <= gate_d;
      dclk_q  <= dclk_d;
      done_q  <= done_d;
      boot_q  <= boot_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    gate_d  = gate_q;
    done_d  = 1'b0;
    boot_d  = boot_q;
    cnt_d   = cnt_q;
    dclk_d  = gate_q & div_in[sel_q];
    rot_en  = auto_en && (dwell != '0);

    unique case (state_q)
      ST_RUN: begin
        // An external accept always beats a dwell expiry on the same edge.
        if (req_valid) begin
          cnt_d = '0;
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = req_sel;
            state_d = ST_DRAIN;
          end
        end else if (!rot_en) begin
          cnt_d = '0;
        end else if (cnt_q >= (dwell - DWELL_W'(1))) begin
          cnt_d   = '0;
          tgt_d   = sel_q + 2'd1;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!div_in[sel_q]) begin
          gate_d  = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        sel_d   = tgt_q;
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        // boot_q suppresses the completion pulse for the opening that follows reset.
        if (!div_in[sel_q]) begin
          gate_d  = 1'b1;
          done_d  = !boot_q;
          boot_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  assign req_ready   = (state_q == ST_RUN);
  assign busy        = !req_ready;
  assign sel         = sel_q;
  assign gate_en     = gate_q;
  assign dclk_out    = dclk_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_dclk_sel_ctrl.sv
// Bench for dclk_sel_ctrl: a cycle-counted divider bank plus a timeline model that predicts
// when the gate closes, the select moves and the gate reopens for each switch.
module tb_dclk_sel_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    div_in;
  logic          req_valid;
  logic [1:0]    req_sel;
  logic          req_ready;
  logic          auto_en;
  logic [DW-1:0] dwell;
  logic [1:0]    sel;
  logic          gate_en;
  logic          dclk_out;
  logic          busy;
  logic          switch_done;

  int n_cmp = 0;
  int n_bad = 0;

  dclk_sel_ctrl #(.DWELL_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_in     (div_in),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .auto_en    (auto_en),
    .dwell      (dwell),
    .sel        (sel),
    .gate_en    (gate_en),
    .dclk_out   (dclk_out),
    .busy       (busy),
    .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  // Divider bank: level of source k just before edge n after reset release.
  function automatic bit lvl(int k, int n);
    case (k)
      0:       return (n % 2) == 1;
      1:       return ((n / 2) % 2) == 1;
      2:       return ((n / 4) % 2) == 1;
      default: return (n % 3) == 2;
    endcase
  endfunction

  function automatic int first_low(int k, int from);
    for (int i = from; i < from + 32; i++)
      if (!lvl(k, i)) return i;
    return from;
  endfunction

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  assign div_in = {lvl(3, cyc), lvl(2, cyc), lvl(1, cyc), lvl(0, cyc)};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: each switch is a schedule of three edge numbers.
  logic [1:0] e_sel, m_tgt;
  bit         e_gate, e_done, e_dclk, e_busy, m_boot;
  int         t_off, t_sel, t_open, m_run;

  always @(posedge clk or negedge rst_n) begin
    int n, toff;
    bit rot, go;
    logic [1:0] nt;
    if (!rst_n) begin
      e_sel <= 2'd0; m_tgt <= 2'd0;
      e_gate <= 1'b0; e_done <= 1'b0; e_dclk <= 1'b0; e_busy <= 1'b1; m_boot <= 1'b1;
      t_off <= -1; t_sel <= -1; t_open <= first_low(0, 0); m_run <= 0;
    end else begin
      n   = cyc;
      rot = auto_en && (dwell != 0);
      go  = 1'b0;
      nt  = e_sel;
      e_dclk <= e_gate & lvl(int'(e_sel), n);
      e_done <= 1'b0;
      if (e_busy) begin
        if (n == t_off) e_gate <= 1'b0;
        if (n == t_sel) e_sel <= m_tgt;
        if (n == t_open) begin
          e_gate <= 1'b1; e_busy <= 1'b0; e_done <= !m_boot; m_boot <= 1'b0; m_run <= 0;
        end
      end else if (req_valid) begin
        m_run <= 0;
        if (req_sel == e_sel) e_done <= 1'b1;
        else begin go = 1'b1; nt = req_sel; end
      end else if (rot && (m_run + 1 >= int'(dwell))) begin
        m_run <= 0; go = 1'b1; nt = e_sel + 2'd1;
      end else begin
        m_run <= rot ? m_run + 1 : 0;
      end
      if (go) begin
        toff    = first_low(int'(e_sel), n + 1);
        m_tgt  <= nt;
        e_busy <= 1'b1;
        t_off  <= toff;
        t_sel  <= toff + 1;
        t_open <= first_low(int'(nt), toff + 2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel", int'(sel), int'(e_sel));
      chk("gate_en", int'(gate_en), int'(e_gate));
      chk("switch_done", int'(switch_done), int'(e_done));
      chk("dclk_out", int'(dclk_out), int'(e_dclk));
      chk("busy", int'(busy), int'(e_busy));
      chk("req_ready", int'(req_ready), int'(!e_busy));
    end
  end

  task automatic wait_busy(input bit v);
    int k;
    k = 0;
    while (busy !== v && k < 300) begin @(negedge clk); k++; end
    if (busy !== v) chk("wait_busy_timeout", int'(busy), int'(v));
  endtask

  task automatic count_run(output int c);
    c = 1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy) return;
      c++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  int rot_exp[3] = '{3, 0, 1};
  int c;

  initial begin
    req_valid = 1'b0; req_sel = 2'd0; auto_en = 1'b0; dwell = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sel", int'(sel), 0);
    chk("rst_gate", int'(gate_en), 0);
    chk("rst_dclk", int'(dclk_out), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done", int'(switch_done), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Gate opens on edge 0 (div_in[0] low) without a completion pulse.
    @(negedge clk);
    chk("boot_gate", int'(gate_en), 1);
    chk("boot_done", int'(switch_done), 0);

    // Minimum-latency switch 0->2 accepted on edge 5.
    while (cyc != 5) @(negedge clk);
    req_valid = 1'b1; req_sel = 2'd2;
    @(negedge clk); req_valid = 1'b0;
    chk("sw_accept_busy", int'(busy), 1);
    @(negedge clk);
    chk("sw_t1_gate", int'(gate_en), 0);
    chk("sw_t1_sel", int'(sel), 0);
    @(negedge clk);
    chk("sw_t2_sel", int'(sel), 2);
    chk("sw_t2_gate", int'(gate_en), 0);
    @(negedge clk);
    chk("sw_t3_gate", int'(gate_en), 1);
    chk("sw_t3_done", int'(switch_done), 1);
    @(negedge clk);
    chk("sw_t4_done", int'(switch_done), 0);

    // Same-source request.
    req_valid = 1'b1; req_sel = 2'd2;
    @(negedge clk); req_valid = 1'b0;
    chk("same_done", int'(switch_done), 1);
    chk("same_gate", int'(gate_en), 1);
    chk("same_busy", int'(busy), 0);
    @(negedge clk);
    chk("same_done_end", int'(switch_done), 0);

    // Auto-rotate with dwell 5: 2 -> 3 -> 0 -> 1, then priority on the expiry edge.
    auto_en = 1'b1; dwell = DW'(5);
    wait_busy(1'b1);
    for (int r = 0; r < 3; r++) begin
      wait_busy(1'b0);
      chk("rot_sel", int'(sel), rot_exp[r]);
      if (r < 2) begin
        count_run(c);
        chk("dwell_run_cycles", c, 5);
      end
    end
    repeat (4) @(negedge clk);
    req_valid = 1'b1; req_sel = 2'd3;
    @(negedge clk); req_valid = 1'b0;
    chk("prio_busy", int'(busy), 1);
    wait_busy(1'b0);
    chk("prio_sel", int'(sel), 3);
    count_run(c);
    chk("prio_dwell_cleared", c, 5);
    wait_busy(1'b0);
    chk("wrap_sel", int'(sel), 0);
    auto_en = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 9) == 0);
      req_sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        auto_en = 1'($urandom_range(0, 1));
        dwell   = DW'($urandom_range(0, 7));
      end
    end

    // Reset during GAP with a request held throughout.
    req_valid = 1'b0; auto_en = 1'b0;
    @(negedge clk);
    wait_busy(1'b0);
    req_valid = 1'b1; req_sel = e_sel + 2'd1;
    @(negedge clk); req_valid = 1'b0;
    c = 0;
    while (!(e_busy && cyc == t_off + 1) && c < 50) begin @(negedge clk); c++; end
    if (c >= 50) chk("gap_search_timeout", c, 0);
    chk("gap_gate", int'(gate_en), 0);
    #2 rst_n = 1'b0;
    req_valid = 1'b1; req_sel = 2'd2;
    #1;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_gate", int'(gate_en), 0);
    chk("mid_rst_dclk", int'(dclk_out), 0);
    chk("mid_rst_done", int'(switch_done), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_ready", int'(req_ready), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_sel", int'(sel), 0);
    chk("rel_gate", int'(gate_en), 1);
    chk("rel_done", int'(switch_done), 0);
    chk("rel_busy", int'(busy), 0);
    @(negedge clk);
    chk("rel_accept_busy", int'(busy), 1);
    req_valid = 1'b0;
    wait_busy(1'b0);
    chk("rel_final_sel", int'(sel), 2);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
